// File: rtl/alu_sequencer.sv
// Command-level controller for the registered 8-bit ALU: runs single ops,
// 16-bit add/subtract with carry chaining and an 8x8 shift-add multiply.
module alu_sequencer #(
  parameter int unsigned MUL_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_s,
  input  logic        cmd_cin,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res,
  output logic        res_cout,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_s,
  output logic        alu_cin,
  input  logic [7:0]  alu_data,
  input  logic        alu_cout
);

  localparam int unsigned CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_ADD16  = 2'b01;
  localparam logic [1:0] OP_SUB16  = 2'b10;
  localparam logic [2:0] S_PASS_A  = 3'b000;
  localparam logic [2:0] S_ADD     = 3'b001;
  localparam logic [2:0] S_SUB     = 3'b010;

  typedef enum logic [2:0] {IDLE, PASS_LO, PASS_HI, MUL, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [7:0]       a_hi_q, b_hi_q, lo_q;
  logic [7:0]       acc_q, mpl_q, mcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;

  // Next multiply accumulator/multiplier after absorbing the current ALU result
  logic       mul_c_c;
  logic [7:0] mul_acc_c, mul_mpl_c;
  always_comb begin
    mul_c_c   = mpl_q[0] ? alu_cout : 1'b0;
    mul_acc_c = {mul_c_c, alu_data[7:1]};
    mul_mpl_c = {alu_data[0], mpl_q[7:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      a_hi_q    <= 8'h00;
      b_hi_q    <= 8'h00;
      lo_q      <= 8'h00;
      acc_q     <= 8'h00;
      mpl_q     <= 8'h00;
      mcd_q     <= 8'h00;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res       <= 16'h0000;
      res_cout  <= 1'b0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_s     <= 3'b000;
      alu_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            a_hi_q    <= cmd_a[15:8];
            b_hi_q    <= cmd_b[15:8];
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            alu_a     <= cmd_a[7:0];
            alu_b     <= cmd_b[7:0];
            state     <= PASS_LO;
            case (cmd_op)
              OP_SINGLE: begin
                alu_s   <= cmd_s;
                alu_cin <= cmd_cin;
              end
              OP_ADD16: begin
                alu_s   <= S_ADD;
                alu_cin <= 1'b0;
              end
              OP_SUB16: begin
                alu_s   <= S_SUB;
                alu_cin <= 1'b1;
              end
              default: begin
                acc_q   <= 8'h00;
                mpl_q   <= cmd_a[7:0];
                mcd_q   <= cmd_b[7:0];
                alu_a   <= 8'h00;
                alu_s   <= cmd_a[0] ? S_ADD : S_PASS_A;
                alu_cin <= 1'b0;
                state   <= MUL;
              end
            endcase
          end
        end
        PASS_LO: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            if (op_q == OP_SINGLE) begin
              res       <= {8'h00, alu_data};
              res_cout  <= alu_cout;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              // High byte reuses the same select, chaining the low carry
              lo_q    <= alu_data;
              alu_a   <= a_hi_q;
              alu_b   <= b_hi_q;
              alu_cin <= alu_cout;
              state   <= PASS_HI;
            end
          end
        end
        PASS_HI: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            res       <= {alu_data, lo_q};
            res_cout  <= alu_cout;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        MUL: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            acc_q <= mul_acc_c;
            mpl_q <= mul_mpl_c;
            if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
              res       <= {mul_acc_c, mul_mpl_c};
              res_cout  <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              alu_a   <= mul_acc_c;
              alu_b   <= mcd_q;
              alu_s   <= mpl_q[1] ? S_ADD : S_PASS_A;
              alu_cin <= 1'b0;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a registered ALU model and a
// whole-word arithmetic reference for each command.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_s;
  logic        cmd_cin;
  logic [15:0] cmd_a, cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res;
  logic        res_cout;
  logic        busy;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_s;
  logic        alu_cin;
  logic [7:0]  alu_data = 8'h00;
  logic        alu_cout = 1'b0;

  alu_sequencer #(.MUL_STEPS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_s(cmd_s), .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .res_cout(res_cout), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_data(alu_data), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The external ALU: 9-bit result {cout, data}
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s, input logic cin);
    logic [8:0] r;
    case (s)
      3'b000:  r = {1'b0, a} + 9'(cin);
      3'b001:  r = {1'b0, a} + {1'b0, b} + 9'(cin);
      3'b010:  r = {1'b0, a} + {1'b0, ~b} + 9'(cin);
      3'b011:  r = {1'b0, a} + 9'h0FF + 9'(cin);
      default: begin
        if (!s[0]) r = {1'b0, cin ? (a | b) : (a & b)};
        else       r = {1'b0, cin ? ~a : (a ^ b)};
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    logic [8:0] r;
    r = alu_fn(alu_a, alu_b, alu_s, alu_cin);
    alu_data <= r[7:0];
    alu_cout <= r[8];
  end

  // Reference: what the requester should get back for a whole command
  task automatic model(input logic [1:0] op, input logic [2:0] s, input logic cin,
                       input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic c, output int lat);
    logic [16:0] w;
    logic [8:0]  n;
    case (op)
      2'b00: begin n = alu_fn(a[7:0], b[7:0], s, cin); r = {8'h00, n[7:0]}; c = n[8]; lat = 2; end
      2'b01: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; lat = 4; end
      2'b10: begin w = {1'b0, a} + {1'b0, ~b} + 17'd1; r = w[15:0]; c = w[16]; lat = 4; end
      default: begin r = 16'(a[7:0] * b[7:0]); c = 1'b0; lat = 16; end
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    res_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares each presented result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (!have_cur) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got res=0x%0h with empty scoreboard", res);
        end else begin
          cur = sb_q.pop_front();
          have_cur = 1'b1;
          chk("latency_cycle", 32'(cyc), 32'(cur.due));
          chk("res", 32'(res), 32'(cur.res));
          chk("res_cout", 32'(res_cout), 32'(cur.cout));
        end
      end else begin
        chk("res_stable", 32'(res), 32'(cur.res));
      end
      chk("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
      chk("busy_in_done", 32'(busy), 32'd1);
      if (res_ready) have_cur = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic cin,
                       input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   lat;
    int   n = 0;
    @(negedge clk);
    cmd_op = op; cmd_s = s; cmd_cin = cin; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    model(op, s, cin, a, b, e.res, e.cout, lat);
    @(posedge clk);
    #1;
    e.due = cyc + lat;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || have_cur) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_res_cout", 32'(res_cout), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_bus", 32'({alu_a, alu_b, alu_s, alu_cin}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_s = 3'b000; cmd_cin = 1'b0;
    cmd_a = 16'h0; cmd_b = 16'h0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    issue(2'b00, 3'b001, 1'b1, 16'h0041, 16'h0002);
    issue(2'b00, 3'b110, 1'b1, 16'h00F0, 16'h000F);
    issue(2'b00, 3'b111, 1'b1, 16'h00F0, 16'h0000);
    issue(2'b01, 3'b000, 1'b0, 16'h12FF, 16'h0001);
    issue(2'b01, 3'b000, 1'b0, 16'hFFFF, 16'h0001);
    issue(2'b10, 3'b000, 1'b0, 16'h1000, 16'h0001);
    issue(2'b10, 3'b000, 1'b0, 16'h0000, 16'h0001);
    issue(2'b11, 3'b000, 1'b0, 16'h0003, 16'h0005);
    issue(2'b11, 3'b000, 1'b0, 16'h00FF, 16'h00FF);
    // Garbage commands while the multiply is running must be ignored
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // Backpressure: result must stay put while the requester stalls
    hold = 1'b1;
    issue(2'b11, 3'b000, 1'b0, 16'h0003, 16'h0005);
    begin
      int n = 0;
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res", 32'(res), 32'h000F);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    hold = 1'b0;
    drain();

    // Reset in the middle of a multiply abandons it
    issue(2'b11, 3'b000, 1'b0, 16'h00A5, 16'h003C);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(2'b01, 3'b000, 1'b0, 16'h12FF, 16'h0001);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-level controller for the team's registered 8-bit ALU (A, B, 3-bit S, Cin in; registered Data and Cout out).
- Accepts one command at a time over a valid/ready handshake.
- Runs the command as one or more 8-bit ALU passes: single op, 16-bit add, 16-bit subtract with carry chaining, or an 8x8 shift-add multiply.
- Returns a 16-bit result over a valid/ready handshake. Sits between a requester (test core or FSM) and the ALU instance.

Parameters:
MUL_STEPS, 8, shift-add iterations for MUL8; equals the ALU width and is not changed.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_op  input  2  00 SINGLE, 01 ADD16, 10 SUB16, 11 MUL8
cmd_s  input  3  ALU select for SINGLE
cmd_cin  input  1  ALU Cin for SINGLE
cmd_a  input  16  operand A; SINGLE/MUL8 use [7:0]
cmd_b  input  16  operand B; SINGLE/MUL8 use [7:0]
res_valid  output  1  result available
res_ready  input  1  requester takes result
res  output  16  result
res_cout  output  1  final carry
busy  output  1  high whenever not IDLE
alu_a  output  8  to ALU A (registered)
alu_b  output  8  to ALU B (registered)
alu_s  output  3  to ALU S (registered)
alu_cin  output  1  to ALU Cin (registered)
alu_data  input  8  from ALU Data
alu_cout  input  1  from ALU Cout, registered alongside alu_data

Behaviour:
- Reset (rst_n low, async): state IDLE; res, res_cout, res_valid, alu_a, alu_b, alu_s, alu_cin, iteration counter and accumulators all 0; cmd_ready=1; busy=0. Reset mid-command abandons the command with no result.
- ALU encoding driven:
  - S=000: A+Cin.
  - S=001: A+B+Cin.
  - S=010: A+~B+Cin.
  - S=011: A+0xFF+Cin.
  - S=1x0 with Cin 0/1: AND/OR.
  - S=1x1 with Cin 0/1: XOR/NOT A.
- Pass timing: alu_* are registered at edge E. The ALU samples them at E+1. The controller captures alu_data/alu_cout at E+2 and may drive the next pass at that same edge. Each pass is 2 cycles.
- States: IDLE, PASS_LO, PASS_HI, MUL, DONE.
- IDLE: cmd_valid&cmd_ready at edge E0 latches the operands, drives the first pass, and moves to PASS_LO (SINGLE/ADD16/SUB16) or MUL.
- SINGLE: drives alu_s=cmd_s, alu_cin=cmd_cin, A/B low bytes. At E0+2: res={8'h00, alu_data}, res_cout=alu_cout, go to DONE. Latency 2.
- ADD16: lo pass S=001, Cin=0. At E0+2: capture the lo byte and drive the hi pass S=001, Cin=alu_cout. At E0+4: res={hi, lo}, res_cout=hi carry, go to DONE. Latency 4.
- SUB16: same as ADD16 with S=010, lo Cin=1. res_cout=1 means no borrow. Latency 4.
- MUL8 registers: acc (8b, init 0), mpl=cmd_a[7:0], mcd=cmd_b[7:0], cnt 0..7.
  - Each iteration drives alu_a=acc, alu_b=mcd, alu_s = mpl[0] ? 001 : 000, alu_cin=0.
  - At capture: c = mpl[0] ? alu_cout : 0, d = alu_data. Then acc <= {c, d[7:1]}, mpl <= {d[0], mpl[7:1]}, cnt+1.
  - The next iteration is driven at the same edge.
  - After iteration 7: res={acc, mpl}, res_cout=0, go to DONE. Latency 16.
- DONE: res_valid=1, res stable. On res_valid&res_ready, go to IDLE. cmd_ready rises the following cycle; no same-cycle re-accept.
- res and res_cout hold their last value in IDLE until the next result is captured.
- cmd_valid while busy is ignored; the command is not latched, and cmd_* may change freely.
- alu_* hold their last driven value outside active passes.

Test Plan:
- SINGLE s=001 cin=1, a=0x0041, b=0x0002 -> res=0x0044, res_cout=0, res_valid 2 cycles after accept.
- SINGLE s=110 cin=1, a=0xF0, b=0x0F -> res=0x00FF (OR); s=111 cin=1, a=0xF0 -> res=0x000F (NOT A).
- ADD16 0x12FF+0x0001 -> res=0x1300, res_cout=0; ADD16 0xFFFF+0x0001 -> res=0x0000, res_cout=1; latency 4.
- SUB16 0x1000-0x0001 -> res=0x0FFF, res_cout=1; SUB16 0x0000-0x0001 -> res=0xFFFF, res_cout=0.
- MUL8 3*5 -> res=0x000F; MUL8 0xFF*0xFF -> res=0xFE01; res_valid exactly 16 cycles after accept; cmd_valid pulses mid-operation ignored.
- Hold res_ready=0 for 5 cycles in DONE -> res stable, cmd_ready=0. Separately, assert rst_n=0 mid-MUL8 -> all outputs 0 immediately, IDLE, and the next command runs correctly.
